// File: rtl/random_word_server.sv
// random_word_server
// Shares one serial random-bit generator among NUM_REQ requesters. A
// round-robin arbiter grants one requester at a time. The word is shifted
// in MSB-first from rnd_bit after a short warm-up discard, then offered on
// a valid/ready handshake. A free-running 12-bit counter stirs the
// generator's xpos input.
module random_word_server #(
    parameter int NUM_REQ = 2,
    parameter int WORD_W  = 8,
    parameter int DISCARD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       rnd_bit,
    output logic [11:0]                gen_xpos,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [WORD_W-1:0]          word,
    output logic [$clog2(NUM_REQ)-1:0] word_id,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic                       busy,
    output logic [15:0]                words_cnt
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int BCW = $clog2(WORD_W + 1);
    localparam int SKW = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_DELIVER = 2'b10
    } state_e;

    // Saturating increment for the delivered-word counter
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [IDW-1:0]      word_id_q, word_id_d;
    logic                word_valid_q, word_valid_d;
    logic                busy_q, busy_d;
    logic [15:0]         words_cnt_q, words_cnt_d;
    logic [11:0]         gen_xpos_q, gen_xpos_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [BCW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [SKW-1:0]      skip_cnt_q, skip_cnt_d;

    logic [IDW-1:0]      pick_idx_s;
    logic                pick_found_s;
    logic [IDW:0]        cand_raw_s;
    logic [IDW:0]        cand_sum_s;
    logic [IDW-1:0]      cand_idx_s;
    logic [IDW:0]        rr_inc_s;
    logic [IDW-1:0]      rr_next_s;
    logic                req_any_s;
    logic                abort_s;
    logic                transfer_s;
    logic                skipping_s;
    logic                last_bit_s;

    assign req_any_s  = |req;
    assign abort_s    = ~req[word_id_q];
    assign transfer_s = word_valid_q & word_ready;
    assign skipping_s = (skip_cnt_q != {SKW{1'b0}});
    assign last_bit_s = (bit_cnt_q == BCW'(WORD_W - 1));

    // Pointer the arbiter starts from after the current word is delivered
    assign rr_inc_s  = {1'b0, word_id_q} + (IDW + 1)'(1);
    assign rr_next_s = (rr_inc_s >= (IDW + 1)'(NUM_REQ)) ? {IDW{1'b0}} : rr_inc_s[IDW-1:0];

    // Round-robin search: first asserted request at or after rr_ptr, wrapping cyclically
    always_comb begin
        pick_idx_s   = {IDW{1'b0}};
        pick_found_s = 1'b0;
        cand_raw_s   = {(IDW + 1){1'b0}};
        cand_sum_s   = {(IDW + 1){1'b0}};
        cand_idx_s   = {IDW{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_raw_s = {1'b0, rr_ptr_q} + (IDW + 1)'(i);
            cand_sum_s = (cand_raw_s >= (IDW + 1)'(NUM_REQ)) ?
                         (cand_raw_s - (IDW + 1)'(NUM_REQ)) : cand_raw_s;
            cand_idx_s = cand_sum_s[IDW-1:0];
            if (!pick_found_s && req[cand_idx_s]) begin
                pick_idx_s   = cand_idx_s;
                pick_found_s = 1'b1;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Next-state logic for the IDLE -> COLLECT -> DELIVER sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any_s) begin
                    state_d = ST_COLLECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (abort_s) begin
                    state_d = ST_IDLE;
                end else if (!skipping_s && last_bit_s) begin
                    state_d = ST_DELIVER;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_DELIVER: begin
                if (transfer_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DELIVER;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values driven by the current state
    always_comb begin
        gnt_d       = gnt_q;
        word_d      = word_q;
        word_id_d   = word_id_q;
        rr_ptr_d    = rr_ptr_q;
        bit_cnt_d   = bit_cnt_q;
        skip_cnt_d  = skip_cnt_q;
        words_cnt_d = words_cnt_q;
        gen_xpos_d  = gen_xpos_q + 12'd1;
        case (state_q)
            ST_IDLE: begin
                if (req_any_s) begin
                    word_id_d  = pick_idx_s;
                    gnt_d      = NUM_REQ'(1) << pick_idx_s;
                    skip_cnt_d = SKW'(DISCARD);
                    bit_cnt_d  = {BCW{1'b0}};
                    word_d     = {WORD_W{1'b0}};
                end else begin
                    gnt_d = {NUM_REQ{1'b0}};
                end
            end
            ST_COLLECT: begin
                if (abort_s) begin
                    // Requester gave up: release the grant, arbitration order untouched
                    gnt_d = {NUM_REQ{1'b0}};
                end else if (skipping_s) begin
                    skip_cnt_d = skip_cnt_q - SKW'(1);
                end else begin
                    word_d    = {word_q[WORD_W-2:0], rnd_bit};
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end
            end
            ST_DELIVER: begin
                if (transfer_s) begin
                    gnt_d       = {NUM_REQ{1'b0}};
                    rr_ptr_d    = rr_next_s;
                    words_cnt_d = sat_inc16(words_cnt_q);
                end else begin
                    gnt_d = gnt_q;
                end
            end
            default: begin
                gnt_d = {NUM_REQ{1'b0}};
            end
        endcase
        word_valid_d = (state_d == ST_DELIVER);
        busy_d       = (state_d != ST_IDLE);
    end

    // State register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q        <= {NUM_REQ{1'b0}};
            word_q       <= {WORD_W{1'b0}};
            word_id_q    <= {IDW{1'b0}};
            word_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            words_cnt_q  <= 16'd0;
            gen_xpos_q   <= 12'd0;
            rr_ptr_q     <= {IDW{1'b0}};
            bit_cnt_q    <= {BCW{1'b0}};
            skip_cnt_q   <= {SKW{1'b0}};
        end else begin
            gnt_q        <= gnt_d;
            word_q       <= word_d;
            word_id_q    <= word_id_d;
            word_valid_q <= word_valid_d;
            busy_q       <= busy_d;
            words_cnt_q  <= words_cnt_d;
            gen_xpos_q   <= gen_xpos_d;
            rr_ptr_q     <= rr_ptr_d;
            bit_cnt_q    <= bit_cnt_d;
            skip_cnt_q   <= skip_cnt_d;
        end
    end

    assign gnt        = gnt_q;
    assign word       = word_q;
    assign word_id    = word_id_q;
    assign word_valid = word_valid_q;
    assign busy       = busy_q;
    assign words_cnt  = words_cnt_q;
    assign gen_xpos   = gen_xpos_q;

endmodule

// File: tb/tb_random_word_server.sv
// Bench for random_word_server (NUM_REQ=2, WORD_W=8, DISCARD=2).
// A transaction-level model (owner, age since grant, collected word) predicts
// all outputs; a compare process checks them every cycle on the falling edge,
// and directed scenarios add hand-computed literal expectations.
module tb_random_word_server;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic        rnd_bit;
    logic [11:0] gen_xpos;
    logic [1:0]  gnt;
    logic [7:0]  word;
    logic [0:0]  word_id;
    logic        word_valid;
    logic        word_ready;
    logic        busy;
    logic [15:0] words_cnt;

    random_word_server #(.NUM_REQ(2), .WORD_W(8), .DISCARD(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .rnd_bit    (rnd_bit),
        .gen_xpos   (gen_xpos),
        .gnt        (gnt),
        .word       (word),
        .word_id    (word_id),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy),
        .words_cnt  (words_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int cyc    = 0;

    // Model state: who holds the generator, how long, what has been collected
    int m_owner;
    int m_age;
    int m_word;
    bit m_deliver;
    int m_rr;
    int m_cnt;
    int m_xpos;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_age     = 0;
        m_word    = 0;
        m_deliver = 1'b0;
        m_rr      = 0;
        m_cnt     = 0;
        m_xpos    = 0;
    endtask

    task automatic model_edge();
        int c;
        if (rst) begin
            model_reset();
        end else begin
            m_xpos = (m_xpos + 1) % 4096;
            if (m_owner < 0) begin
                for (int k = 0; k < 2; k++) begin
                    c = (m_rr + k) % 2;
                    if (m_owner < 0 && req[c]) begin
                        m_owner   = c;
                        m_age     = 0;
                        m_word    = 0;
                        m_deliver = 1'b0;
                    end
                end
            end else if (!m_deliver) begin
                if (!req[m_owner]) begin
                    m_owner = -1;
                end else begin
                    if (m_age >= 2) m_word = ((m_word * 2) + int'(rnd_bit)) % 256;
                    m_age = m_age + 1;
                    if (m_age == 10) m_deliver = 1'b1;
                end
            end else if (word_ready) begin
                m_rr      = (m_owner + 1) % 2;
                m_cnt     = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
                m_owner   = -1;
                m_deliver = 1'b0;
            end
        end
    endtask

    function automatic logic [1:0] exp_gnt();
        logic [1:0] one;
        one = 2'b01;
        if (m_owner < 0) return 2'b00;
        return one << m_owner;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic sync_reset();
        chk_en = 1'b0;
        rst    = 1'b1;
        model_reset();
        step();
        step();
        rst    = 1'b0;
        chk_en = 1'b1;
    endtask

    // Per-cycle comparison of every output against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("gnt", 32'(gnt), 32'(exp_gnt()));
                chk("busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
                chk("word_valid", 32'(word_valid), 32'(m_deliver));
                if (m_deliver) begin
                    chk("word", 32'(word), 32'(m_word));
                    chk("word_id", 32'(word_id), 32'(m_owner));
                end
                chk("words_cnt", 32'(words_cnt), 32'(m_cnt));
                chk("gen_xpos", 32'(gen_xpos), 32'(m_xpos));
            end
        end
    end

    int          n;
    int          ids[$];
    int          vcyc[$];
    logic [9:0]  seq;

    initial begin
        rst        = 1'b1;
        req        = 2'b00;
        rnd_bit    = 1'b0;
        word_ready = 1'b0;
        model_reset();
        step();
        step();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_word", 32'(word), 32'd0);
        chk("rst_word_id", 32'(word_id), 32'd0);
        chk("rst_word_valid", 32'(word_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_words_cnt", 32'(words_cnt), 32'd0);
        chk("rst_gen_xpos", 32'(gen_xpos), 32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Scenario 1: single requester, all-ones bits, latency 11
        req        = 2'b01;
        rnd_bit    = 1'b1;
        word_ready = 1'b1;
        step();
        chk("t1_gnt_cycle1", 32'(gnt), 32'd1);
        n = 1;
        while (!word_valid && n < 40) begin
            step();
            n = n + 1;
        end
        chk("t1_latency", 32'(n), 32'd11);
        chk("t1_word", 32'(word), 32'hFF);
        chk("t1_word_id", 32'(word_id), 32'd0);
        step();
        chk("t1_valid_drop", 32'(word_valid), 32'd0);
        chk("t1_words_cnt", 32'(words_cnt), 32'd1);
        req = 2'b00;
        step();

        // Scenario 2: both requesting from reset, grants alternate, 12-cycle period
        sync_reset();
        req        = 2'b11;
        word_ready = 1'b1;
        for (int k = 0; k < 100 && ids.size() < 4; k++) begin
            rnd_bit = 1'($urandom_range(0, 1));
            step();
            if (word_valid) begin
                ids.push_back(int'(word_id));
                vcyc.push_back(cyc);
                if (ids.size() == 4) req = 2'b00;
            end
        end
        step();
        step();
        chk("t2_word_count", 32'(ids.size()), 32'd4);
        if (ids.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("t2_id_seq", 32'(ids[k]), 32'(k % 2));
            for (int k = 0; k < 3; k++) chk("t2_period", 32'(vcyc[k+1] - vcyc[k]), 32'd12);
        end
        chk("t2_words_cnt", 32'(words_cnt), 32'd4);

        // Scenario 3: known bit stream for requester 1 -> 8'hB2
        seq        = 10'b10_1011_0010;
        req        = 2'b10;
        word_ready = 1'b0;
        step();
        chk("t3_gnt", 32'(gnt), 32'd2);
        for (int j = 0; j < 10; j++) begin
            rnd_bit = seq[9-j];
            step();
        end
        chk("t3_valid", 32'(word_valid), 32'd1);
        chk("t3_word", 32'(word), 32'hB2);
        chk("t3_word_id", 32'(word_id), 32'd1);

        // Scenario 4: consumer stalls 20 cycles, everything held
        for (int j = 0; j < 20; j++) begin
            rnd_bit = 1'($urandom_range(0, 1));
            step();
            chk("t4_valid_held", 32'(word_valid), 32'd1);
            chk("t4_word_held", 32'(word), 32'hB2);
            chk("t4_gnt_held", 32'(gnt), 32'd2);
        end
        word_ready = 1'b1;
        step();
        chk("t4_transfer", 32'(word_valid), 32'd0);
        chk("t4_words_cnt", 32'(words_cnt), 32'd5);
        req = 2'b00;
        step();

        // Scenario 5: requester 0 drops mid-collect, keeps its turn afterwards
        req = 2'b01;
        step();
        chk("t5_gnt", 32'(gnt), 32'd1);
        for (int j = 0; j < 6; j++) begin
            rnd_bit = 1'($urandom_range(0, 1));
            step();
        end
        req = 2'b00;
        step();
        chk("t5_abort_gnt", 32'(gnt), 32'd0);
        chk("t5_abort_busy", 32'(busy), 32'd0);
        chk("t5_abort_cnt", 32'(words_cnt), 32'd5);
        step();
        step();
        step();
        req = 2'b11;
        step();
        chk("t5_req0_first", 32'(gnt), 32'd1);
        for (int k = 0; k < 20 && !word_valid; k++) begin
            rnd_bit = 1'($urandom_range(0, 1));
            step();
        end
        chk("t5_valid", 32'(word_valid), 32'd1);
        req = 2'b00;
        step();
        chk("t5_words_cnt", 32'(words_cnt), 32'd6);

        // Scenario 6: asynchronous reset mid-collect, then xpos count and wrap
        req = 2'b01;
        step();
        for (int j = 0; j < 4; j++) step();
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_gnt", 32'(gnt), 32'd0);
        chk("t6_async_valid", 32'(word_valid), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_word", 32'(word), 32'd0);
        chk("t6_async_word_id", 32'(word_id), 32'd0);
        chk("t6_async_cnt", 32'(words_cnt), 32'd0);
        chk("t6_async_xpos", 32'(gen_xpos), 32'd0);
        model_reset();
        req = 2'b00;
        step();
        rst = 1'b0;
        chk("t6_xpos0", 32'(gen_xpos), 32'd0);
        step();
        chk("t6_xpos1", 32'(gen_xpos), 32'd1);
        step();
        chk("t6_xpos2", 32'(gen_xpos), 32'd2);
        repeat (4094) step();
        chk("t6_xpos_wrap", 32'(gen_xpos), 32'd0);
        step();
        chk("t6_xpos_after_wrap", 32'(gen_xpos), 32'd1);
        chk("t6_cnt_after_reset", 32'(words_cnt), 32'd0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
